sn_mem_rd_seq: RTL and testbench

Read sequencer for the SNN's 1-read/1-write neuron-state memories, which have a registered read port. On a start command it streams a contiguous, wrap-around range of rows out of the memory read port. It presents each row on a valid/ready output stream, with full backpressure, to the neuron evaluation pipeline or the API transmit path. It asserts a done pulse when the last row has been accepted downstream.

---
 rtl/sn_mem_pkg.sv | 32 +++
 rtl/sn_mem_rd_seq_if.sv | 34 +++
 rtl/sn_fwft_fifo.sv | 64 ++++++
 rtl/sn_mem_rd_seq_chk.sv | 26 ++
 rtl/sn_mem_rd_seq.sv | 136 +++++++++++++
 tb/tb_sn_mem_rd_seq.sv | 236 +++++++++++++++++++++++
 6 files changed

// File: rtl/sn_mem_pkg.sv
// Shared types and constants for the neuron-state memory read sequencer.
// Holds the FSM state encoding, the output FIFO geometry and the FIFO entry layout.
package sn_mem_pkg;

    localparam int SN_DATA_WIDTH = 21;
    localparam int SN_NUM_ROWS   = 1000;
    localparam int SN_ADDR_WIDTH = $clog2(SN_NUM_ROWS);
    localparam int FIFO_DEPTH    = 3;
    localparam int FIFO_CNT_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [SN_DATA_WIDTH-1:0] data;
        logic [SN_ADDR_WIDTH-1:0] addr;
        logic                     last;
    } fifo_entry_t;

    // Circular pointer increment over the FIFO_DEPTH slots (depth is not a power of two).
    function automatic logic [FIFO_CNT_W-1:0] fifo_ptr_inc(input logic [FIFO_CNT_W-1:0] ptr);
        if (ptr == FIFO_CNT_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end else begin
            return ptr + FIFO_CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/sn_mem_rd_seq_if.sv
// Command, memory read port and output stream bundle of the read sequencer.
// master = the sequencer, slave = its environment (controller, memory, consumer).
interface sn_mem_rd_seq_if #(
    parameter int P_DATA_WIDTH = 21,
    parameter int P_NUM_ROWS   = 1000
);
    localparam int AW = $clog2(P_NUM_ROWS);
    localparam int CW = $clog2(P_NUM_ROWS + 1);

    logic                    start;
    logic [AW-1:0]           start_addr;
    logic [CW-1:0]           row_count;
    logic                    busy;
    logic                    done;
    logic                    mem_re;
    logic [AW-1:0]           mem_raddr;
    logic [P_DATA_WIDTH-1:0] mem_rdata;
    logic                    out_valid;
    logic                    out_ready;
    logic [P_DATA_WIDTH-1:0] out_data;
    logic [AW-1:0]           out_addr;
    logic                    out_last;

    modport master (
        input  start, start_addr, row_count, mem_rdata, out_ready,
        output busy, done, mem_re, mem_raddr, out_valid, out_data, out_addr, out_last
    );

    modport slave (
        output start, start_addr, row_count, mem_rdata, out_ready,
        input  busy, done, mem_re, mem_raddr, out_valid, out_data, out_addr, out_last
    );

endinterface

// File: rtl/sn_fwft_fifo.sv
// Three-entry first-word-fall-through FIFO; the head entry is visible whenever not empty.
// A push into a full FIFO is accepted only when the head is popped in the same cycle.
module sn_fwft_fifo
    import sn_mem_pkg::*;
#(
    parameter int P_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [P_WIDTH-1:0]    push_data,
    input  logic                  pop,
    output logic [P_WIDTH-1:0]    pop_data,
    output logic                  empty,
    output logic                  full,
    output logic [FIFO_CNT_W-1:0] count
);

    localparam logic [FIFO_CNT_W-1:0] DEPTH_C = FIFO_CNT_W'(FIFO_DEPTH);

    logic [P_WIDTH-1:0]    store_r [FIFO_DEPTH];
    logic [FIFO_CNT_W-1:0] wr_ptr_r;
    logic [FIFO_CNT_W-1:0] rd_ptr_r;
    logic [FIFO_CNT_W-1:0] count_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    // Qualify push/pop against the current occupancy.
    always_comb begin
        do_pop_s  = pop && (count_r != '0);
        do_push_s = push && ((count_r != DEPTH_C) || do_pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                store_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                store_r[wr_ptr_r] <= push_data;
                wr_ptr_r          <= fifo_ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= fifo_ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + FIFO_CNT_W'(1);
                2'b01:   count_r <= count_r - FIFO_CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = store_r[rd_ptr_r];
    assign empty    = (count_r == '0);
    assign full     = (count_r == DEPTH_C);
    assign count    = count_r;

endmodule

// File: rtl/sn_mem_rd_seq_chk.sv
// Property checks for the read sequencer: legal start address and no FIFO overflow.
module sn_mem_rd_seq_chk #(
    parameter int P_NUM_ROWS = 1000
) (
    input logic                          clk,
    input logic                          rst,
    input logic                          start,
    input logic                          busy,
    input logic [$clog2(P_NUM_ROWS)-1:0] start_addr,
    input logic                          push,
    input logic                          pop,
    input logic                          full
);

    localparam int AW = $clog2(P_NUM_ROWS);
    localparam logic [AW-1:0] LAST_ADDR_C = AW'(P_NUM_ROWS - 1);

    a_start_addr_legal: assert property (
        @(posedge clk) disable iff (rst) (start && !busy) |-> (start_addr <= LAST_ADDR_C)
    );

    a_fifo_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(push && full && !pop)
    );

endmodule

// File: rtl/sn_mem_rd_seq.sv
// Streams a contiguous wrap-around range of rows from a registered-read memory
// onto a valid/ready stream, keeping at most three words in flight or buffered.
module sn_mem_rd_seq
    import sn_mem_pkg::*;
#(
    parameter int P_DATA_WIDTH = SN_DATA_WIDTH,
    parameter int P_NUM_ROWS   = SN_NUM_ROWS
) (
    input logic             clk,
    input logic             rst,
    sn_mem_rd_seq_if.master bus
);

    localparam int AW = $clog2(P_NUM_ROWS);
    localparam int CW = $clog2(P_NUM_ROWS + 1);
    localparam int EW = $bits(fifo_entry_t);
    localparam logic [CW-1:0] ROWS_C      = CW'(P_NUM_ROWS);
    localparam logic [AW-1:0] LAST_ADDR_C = AW'(P_NUM_ROWS - 1);

    seq_state_t            state_r;
    logic [AW-1:0]         addr_r;
    logic [CW-1:0]         remaining_r;
    logic                  inflight_r;
    logic [AW-1:0]         cap_addr_r;
    logic                  cap_last_r;
    logic                  done_r;

    logic [CW-1:0]         start_count_s;
    logic                  issue_s;
    logic                  pop_s;
    logic [FIFO_CNT_W-1:0] fifo_count_s;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic [P_DATA_WIDTH-1:0] rdata_s;
    fifo_entry_t           push_entry_s;
    fifo_entry_t           head_entry_s;

    assign rdata_s = bus.mem_rdata;

    // Command clamp, read-issue throttle and capture entry assembly.
    always_comb begin
        start_count_s     = (bus.row_count > ROWS_C) ? ROWS_C : bus.row_count;
        issue_s           = (state_r == ST_RUN) &&
                            (({1'b0, fifo_count_s} + {2'b00, inflight_r}) < 3'(FIFO_DEPTH));
        pop_s             = !fifo_empty_s && bus.out_ready;
        push_entry_s.data = SN_DATA_WIDTH'(rdata_s);
        push_entry_s.addr = SN_ADDR_WIDTH'(cap_addr_r);
        push_entry_s.last = cap_last_r;
    end

    // Sequencer FSM with read-address generation and capture tagging.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            remaining_r <= '0;
            inflight_r  <= 1'b0;
            cap_addr_r  <= '0;
            cap_last_r  <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            inflight_r <= issue_s;
            if (issue_s) begin
                cap_addr_r <= addr_r;
                cap_last_r <= (remaining_r == CW'(1));
            end
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (start_count_s == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            state_r     <= ST_RUN;
                            addr_r      <= bus.start_addr;
                            remaining_r <= start_count_s;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue_s) begin
                        addr_r      <= (addr_r == LAST_ADDR_C) ? '0 : addr_r + AW'(1);
                        remaining_r <= remaining_r - CW'(1);
                        if (remaining_r == CW'(1)) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop_s && head_entry_s.last) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b1;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    sn_fwft_fifo #(
        .P_WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_r),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .pop_data  (head_entry_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .count     (fifo_count_s)
    );

    sn_mem_rd_seq_chk #(
        .P_NUM_ROWS (P_NUM_ROWS)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .start      (bus.start),
        .busy       (bus.busy),
        .start_addr (bus.start_addr),
        .push       (inflight_r),
        .pop        (pop_s),
        .full       (fifo_full_s)
    );

    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.done      = done_r;
    assign bus.mem_re    = issue_s;
    assign bus.mem_raddr = addr_r;
    assign bus.out_valid = !fifo_empty_s;
    assign bus.out_data  = P_DATA_WIDTH'(head_entry_s.data);
    assign bus.out_addr  = AW'(head_entry_s.addr);
    assign bus.out_last  = head_entry_s.last;

endmodule

// File: tb/tb_sn_mem_rd_seq.sv
// Bench for sn_mem_rd_seq: vector table of commands, per-word reference queue,
// plus hand sequences for zero-length commands and reset mid-command.
module tb_sn_mem_rd_seq;

    localparam int DW = 21;
    localparam int NR = 1000;
    localparam int AW = $clog2(NR);
    localparam int CW = $clog2(NR + 1);

    typedef struct {
        int sa;
        int rc;
        int mode;
        bit poke;
        int exp_first;
        int exp_last_addr;
        int exp_words;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] mem [NR];
    logic [DW-1:0] rdata_q = '0;
    vec_t          vecs [6];

    sn_mem_rd_seq_if #(.P_DATA_WIDTH(DW), .P_NUM_ROWS(NR)) bus ();

    sn_mem_rd_seq #(.P_DATA_WIDTH(DW), .P_NUM_ROWS(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Registered-read memory model: output holds while re is low.
    always @(posedge clk) begin
        if (bus.mem_re) rdata_q <= mem[bus.mem_raddr];
    end
    assign bus.mem_rdata = rdata_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3) == 0;
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  int'(bus.busy), 0);
        check({tag, "_done"},  int'(bus.done), 0);
        check({tag, "_re"},    int'(bus.mem_re), 0);
        check({tag, "_raddr"}, int'(bus.mem_raddr), 0);
        check({tag, "_valid"}, int'(bus.out_valid), 0);
        check({tag, "_data"},  int'(bus.out_data), 0);
        check({tag, "_addr"},  int'(bus.out_addr), 0);
        check({tag, "_last"},  int'(bus.out_last), 0);
    endtask

    // Issue one command at the current sample point and follow it to done.
    task automatic run_cmd(input int sa, input int rc, input int mode, input bit poke,
                           output int first_data, output int last_addr, output int words);
        int qa[$];
        int n, cyc, issued, accepted, first_valid, last_hs, a;
        bit done_seen, stalled;
        int hd, ha, hl;
        n = (rc > NR) ? NR : rc;
        for (int k = 0; k < n; k++) qa.push_back((sa + k) % NR);
        first_data = -1; last_addr = -1; words = 0;
        cyc = 0; issued = 0; accepted = 0; first_valid = -1; last_hs = -1;
        done_seen = 1'b0; stalled = 1'b0; hd = 0; ha = 0; hl = 0;
        bus.start = 1'b1;
        bus.start_addr = AW'(sa);
        bus.row_count = CW'(rc);
        bus.out_ready = 1'b0;
        tick();
        bus.start = 1'b0;
        check("busy_after_start", int'(bus.busy), 1);
        while (cyc < n * 4 + 50) begin
            if (bus.done) begin
                done_seen = 1'b1;
                check("done_after_last_hs", cyc, last_hs + 1);
                check("busy_low_with_done", int'(bus.busy), 0);
                break;
            end
            bus.start = poke && (cyc == 1);
            bus.start_addr = AW'(poke ? 100 : sa);
            bus.row_count = CW'(poke ? 5 : rc);
            bus.out_ready = ready_for(mode, cyc);
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            if (stalled) begin
                check("hold_data", int'(bus.out_data), hd);
                check("hold_addr", int'(bus.out_addr), ha);
                check("hold_last", int'(bus.out_last), hl);
            end
            if (bus.mem_re) begin
                n_tests++;
                if (issued - accepted >= 3) begin
                    n_fail++;
                    $display("FAIL re_occupancy: re with occupancy %0d required < 3", issued - accepted);
                end
                issued++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (qa.size() == 0) begin
                    check("extra_word_addr", int'(bus.out_addr), -1);
                end else begin
                    a = qa.pop_front();
                    check("word_addr", int'(bus.out_addr), a);
                    check("word_data", int'(bus.out_data), a + 'h100);
                    check("word_last", int'(bus.out_last), (qa.size() == 0) ? 1 : 0);
                    if (mode == 0) check("throughput_cycle", cyc, 2 + accepted);
                end
                if (accepted == 0) first_data = int'(bus.out_data);
                if (bus.out_last) last_addr = int'(bus.out_addr);
                accepted++;
                last_hs = cyc;
            end
            stalled = bus.out_valid && !bus.out_ready;
            hd = int'(bus.out_data); ha = int'(bus.out_addr); hl = int'(bus.out_last);
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        words = accepted;
        check("done_seen", int'(done_seen), 1);
        check("missing_words", qa.size(), 0);
        check("reads_issued", issued, n);
        check("first_valid_latency", first_valid, 2);
    endtask

    initial begin
        int fd, la, wc, sa, rc;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.start_addr = '0;
        bus.row_count = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < NR; i++) mem[i] = DW'(i + 'h100);

        vecs[0] = '{5,   4,    0, 1'b1, 'h105, 8,   4};
        vecs[1] = '{998, 4,    0, 1'b0, 'h4E6, 1,   4};
        vecs[2] = '{0,   10,   1, 1'b0, 'h100, 9,   10};
        vecs[3] = '{999, 1,    0, 1'b0, 'h4E7, 999, 1};
        vecs[4] = '{0,   1023, 0, 1'b0, 'h100, 999, 1000};
        vecs[5] = '{500, 1000, 2, 1'b0, 'h2F4, 499, 1000};

        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Zero-length command: done next cycle, nothing read or emitted.
        bus.start = 1'b1; bus.start_addr = AW'(7); bus.row_count = '0;
        tick();
        bus.start = 1'b0;
        check("zero_done", int'(bus.done), 1);
        check("zero_busy", int'(bus.busy), 0);
        check("zero_re", int'(bus.mem_re), 0);
        check("zero_valid", int'(bus.out_valid), 0);
        tick();
        check("zero_done_pulse", int'(bus.done), 0);
        check("zero_re2", int'(bus.mem_re), 0);
        check("zero_valid2", int'(bus.out_valid), 0);

        for (int v = 0; v < 6; v++) begin
            run_cmd(vecs[v].sa, vecs[v].rc, vecs[v].mode, vecs[v].poke, fd, la, wc);
            check("vec_first_data", fd, vecs[v].exp_first);
            check("vec_last_addr", la, vecs[v].exp_last_addr);
            check("vec_words", wc, vecs[v].exp_words);
            if (vecs[v].poke) begin
                for (int k = 0; k < 4; k++) begin
                    tick();
                    check("ignored_start_busy", int'(bus.busy), 0);
                    check("ignored_start_valid", int'(bus.out_valid), 0);
                end
            end
        end

        // Reset during the third beat of a 10-row read.
        bus.start = 1'b1; bus.start_addr = '0; bus.row_count = CW'(10); bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("pre_rst_valid", int'(bus.out_valid), 1);
        check("pre_rst_addr", int'(bus.out_addr), 2);
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("post_rst_done", int'(bus.done), 0);
            check("post_rst_valid", int'(bus.out_valid), 0);
        end
        run_cmd(20, 2, 0, 1'b0, fd, la, wc);
        check("post_rst_first", fd, 'h114);
        check("post_rst_last_addr", la, 21);
        check("post_rst_words", wc, 2);

        // Random commands against the reference queue.
        for (int r = 0; r < 20; r++) begin
            sa = $urandom_range(0, NR - 1);
            rc = (r == 7) ? 1023 : $urandom_range(1, 60);
            run_cmd(sa, rc, 2, 1'b0, fd, la, wc);
            check("rand_words", wc, (rc > NR) ? NR : rc);
            check("rand_last_addr", la, (sa + ((rc > NR) ? NR : rc) - 1) % NR);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
